por_rst_seq: RTL and testbench

//  Receiving end of the POR pulse. Consumes the asynchronous active-high POR pulse
//  (por_unbuf after buffering) in the osc_ck domain and synchronises it.

---
 rtl/por_rst_seq.sv | 168 ++++++++++++++++
 tb/tb_por_rst_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/por_rst_seq.sv
// POR receiver: synchronises the POR pulse, qualifies it by width, and releases
// NUM_DOM active-low domain resets in order, keeping sticky status for debug.
`timescale 1ns/1ps
module por_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 16,
    parameter int NUM_DOM     = 3,
    parameter int STAGE_DLY   = 8,
    parameter int WCNT_W      = 16
) (
    input  logic               osc_ck,
    input  logic               pwup_rsb,
    input  logic               por_in,
    input  logic               clr_stat,
    output logic [NUM_DOM-1:0] rstb_out,
    output logic               busy,
    output logic               por_seen,
    output logic               glitch_seen,
    output logic [WCNT_W-1:0]  por_width,
    output logic [7:0]         por_cnt
);

    localparam int DCNT_W = $clog2(NUM_DOM * STAGE_DLY + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] MIN_W    = WCNT_W'(MIN_WIDTH);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_MEAS = 2'd1,
        ST_REL  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 w_por_s;
    logic [WCNT_W-1:0]    r_wcnt, w_wcnt_nxt;
    logic [DCNT_W-1:0]    r_dcnt, w_dcnt_nxt, w_dcnt_inc;
    logic [NUM_DOM-1:0]   r_rstb, w_rstb_nxt, w_rel_mask;
    logic                 r_busy, w_busy_nxt;
    logic                 r_seen, w_seen_nxt;
    logic                 r_glitch, w_glitch_nxt;
    logic [WCNT_W-1:0]    r_width, w_width_nxt;
    logic [7:0]           r_cnt, w_cnt_nxt;

    function automatic logic [WCNT_W-1:0] sat_inc_w(input logic [WCNT_W-1:0] v);
        return (v == WCNT_MAX) ? v : v + WCNT_ONE;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge osc_ck or negedge pwup_rsb) begin
        if (!pwup_rsb) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], por_in};
        end
    end

    assign w_por_s    = r_sync[SYNC_STAGES-1];
    assign w_dcnt_inc = r_dcnt + DCNT_W'(1);

    // Domain i is released once the post-increment count reaches (i+1)*STAGE_DLY.
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            w_rel_mask[i] = (w_dcnt_inc >= DCNT_W'((i + 1) * STAGE_DLY));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_dcnt_nxt   = r_dcnt;
        w_rstb_nxt   = r_rstb;
        w_width_nxt  = r_width;
        w_seen_nxt   = clr_stat ? 1'b0 : r_seen;
        w_glitch_nxt = clr_stat ? 1'b0 : r_glitch;
        w_cnt_nxt    = clr_stat ? 8'd0 : r_cnt;
        case (r_state)
            ST_WAIT: begin
                w_rstb_nxt = '0;
                if (w_por_s) begin
                    w_state_nxt = ST_MEAS;
                    w_wcnt_nxt  = WCNT_ONE;
                end
            end
            ST_MEAS: begin
                w_rstb_nxt = '0;
                if (w_por_s) begin
                    w_wcnt_nxt = sat_inc_w(r_wcnt);
                end else begin
                    // A completing event overrides a coincident clr_stat.
                    w_state_nxt = ST_REL;
                    w_dcnt_nxt  = '0;
                    if (r_wcnt >= MIN_W) begin
                        w_width_nxt = r_wcnt;
                        w_cnt_nxt   = sat_inc8(clr_stat ? 8'd0 : r_cnt);
                        w_seen_nxt  = 1'b1;
                    end else begin
                        w_glitch_nxt = 1'b1;
                    end
                end
            end
            ST_REL: begin
                if (w_por_s) begin
                    w_state_nxt = ST_MEAS;
                    w_wcnt_nxt  = WCNT_ONE;
                    w_rstb_nxt  = '0;
                end else begin
                    w_dcnt_nxt = w_dcnt_inc;
                    w_rstb_nxt = w_rel_mask;
                    if (w_rel_mask[NUM_DOM-1]) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_rstb_nxt = '1;
                if (w_por_s) begin
                    w_state_nxt = ST_MEAS;
                    w_wcnt_nxt  = WCNT_ONE;
                    w_rstb_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_rstb_nxt  = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_MEAS) || (w_state_nxt == ST_REL);
    end

    always_ff @(posedge osc_ck or negedge pwup_rsb) begin
        if (!pwup_rsb) begin
            r_state  <= ST_WAIT;
            r_wcnt   <= '0;
            r_dcnt   <= '0;
            r_rstb   <= '0;
            r_busy   <= 1'b0;
            r_seen   <= 1'b0;
            r_glitch <= 1'b0;
            r_width  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_rstb   <= w_rstb_nxt;
            r_busy   <= w_busy_nxt;
            r_seen   <= w_seen_nxt;
            r_glitch <= w_glitch_nxt;
            r_width  <= w_width_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign rstb_out    = r_rstb;
    assign busy        = r_busy;
    assign por_seen    = r_seen;
    assign glitch_seen = r_glitch;
    assign por_width   = r_width;
    assign por_cnt     = r_cnt;

endmodule

// File: tb/tb_por_rst_seq.sv
// Scoreboard bench for por_rst_seq: stimulus pushes expected output events,
// a monitor pops one whenever {busy, rstb_out} changes and compares it.
`timescale 1ns/1ps
module tb_por_rst_seq;

    logic        osc_ck = 1'b0;
    logic        pwup_rsb, por_in, clr_stat;
    logic [2:0]  rstb_out;
    logic        busy, por_seen, glitch_seen;
    logic [15:0] por_width;
    logic [7:0]  por_cnt;

    por_rst_seq dut (
        .osc_ck      (osc_ck),
        .pwup_rsb    (pwup_rsb),
        .por_in      (por_in),
        .clr_stat    (clr_stat),
        .rstb_out    (rstb_out),
        .busy        (busy),
        .por_seen    (por_seen),
        .glitch_seen (glitch_seen),
        .por_width   (por_width),
        .por_cnt     (por_cnt)
    );

    always #5 osc_ck = ~osc_ck;

    typedef struct {
        logic [2:0] rstb;
        logic       busy;
        int         cyc;     // absolute edge index, -1 = don't care
        logic       seen;
        logic       glitch;
        int         width;
        int         cnt;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 0;

    int  m_width = 0, m_cnt = 0;
    bit  m_seen = 0, m_glitch = 0;

    always @(posedge osc_ck) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] r, input logic b, input int c);
        ev_t e;
        e.rstb = r; e.busy = b; e.cyc = c;
        e.seen = m_seen; e.glitch = m_glitch; e.width = m_width; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // Monitor: every change of {busy, rstb_out} is an output event
    logic [3:0] prev = 4'h0;
    always @(negedge osc_ck) begin
        logic [3:0] cur;
        ev_t e;
        cur = {busy, rstb_out};
        if (mon_en && cur !== prev) begin
            if (q.size() == 0) begin
                chk("unexpected_event", int'(cur), -1);
            end else begin
                e = q.pop_front();
                chk("ev_rstb", int'(rstb_out), int'(e.rstb));
                chk("ev_busy", int'(busy), int'(e.busy));
                if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
                chk("ev_por_seen", int'(por_seen), int'(e.seen));
                chk("ev_glitch_seen", int'(glitch_seen), int'(e.glitch));
                chk("ev_por_width", int'(por_width), e.width);
                chk("ev_por_cnt", int'(por_cnt), e.cnt);
            end
        end
        prev = cur;
    end

    // One por_in pulse of w cycles; ndom = domain releases to wait for.
    task automatic pulse(input int w, input int ndom, input bit clr);
        int k, f, target;
        @(negedge osc_ck);
        k = cyc + 1;
        por_in = 1'b1;
        push(3'b000, 1'b1, k + 2);
        repeat (w) @(negedge osc_ck);
        por_in = 1'b0;
        f = cyc + 1;
        if (clr) begin m_cnt = 0; m_seen = 0; m_glitch = 0; end
        if (w >= 16) begin
            m_width = (w > 65535) ? 65535 : w;
            m_cnt   = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_seen  = 1;
        end else begin
            m_glitch = 1;
        end
        for (int i = 0; i < ndom; i++)
            push(3'((1 << (i + 1)) - 1), (i < 2), f + 2 + 8 * (i + 1));
        if (clr) begin
            while (cyc < f + 1) @(negedge osc_ck);
            clr_stat = 1'b1;
            @(negedge osc_ck);
            clr_stat = 1'b0;
        end
        target = f + 2 + 8 * ndom + ((ndom == 3) ? 2 : 0);
        while (cyc < target) @(negedge osc_ck);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        pwup_rsb = 1'b1; por_in = 1'b0; clr_stat = 1'b0;
        #1 pwup_rsb = 1'b0;
        #2;
        chk("rst_rstb", int'(rstb_out), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge osc_ck);
        pwup_rsb = 1'b1;
        mon_en = 1'b1;

        // Test 1: idle for 100 cycles
        repeat (100) @(negedge osc_ck);
        chk("idle_rstb", int'(rstb_out), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_por_seen", int'(por_seen), 0);
        chk("idle_glitch_seen", int'(glitch_seen), 0);
        chk("idle_por_width", int'(por_width), 0);
        chk("idle_por_cnt", int'(por_cnt), 0);

        // Test 2: 40-cycle valid POR
        pulse(40, 3, 0);
        chk("t2_por_width", int'(por_width), 40);
        chk("t2_por_cnt", int'(por_cnt), 1);

        // Test 3: glitches of 5 and 15 cycles
        pulse(5, 3, 0);
        chk("t3_glitch_seen", int'(glitch_seen), 1);
        chk("t3_por_width", int'(por_width), 40);
        chk("t3_por_cnt", int'(por_cnt), 1);
        pulse(15, 3, 0);

        // Test 4: valid POR interrupted at 001 by a 20-cycle pulse
        pulse(30, 1, 0);
        chk("t4_rstb_mid", int'(rstb_out), 1);
        pulse(20, 3, 0);
        chk("t4_por_width", int'(por_width), 20);
        chk("t4_por_cnt", int'(por_cnt), 3);

        // Test 5a: minimum-width pulses until the counter saturates
        for (int n = 0; n < 300; n++) pulse(16, 3, 0);
        chk("t5a_por_cnt", int'(por_cnt), 255);
        chk("t5a_por_width", int'(por_width), 16);

        // Test 5b: clr_stat coincides with POR completion
        pulse(25, 3, 1);
        chk("t5b_por_cnt", int'(por_cnt), 1);
        chk("t5b_por_seen", int'(por_seen), 1);
        chk("t5b_glitch_seen", int'(glitch_seen), 0);

        // Test 6a: width counter saturation
        pulse(70000, 3, 0);
        chk("t6a_por_width", int'(por_width), 65535);

        // Test 6b: async reset mid-RELEASE
        pulse(30, 1, 0);
        #2;
        pwup_rsb = 1'b0;
        m_width = 0; m_cnt = 0; m_seen = 0; m_glitch = 0;
        push(3'b000, 1'b0, -1);
        #1;
        chk("t6b_rstb", int'(rstb_out), 0);
        chk("t6b_busy", int'(busy), 0);
        chk("t6b_por_seen", int'(por_seen), 0);
        chk("t6b_por_width", int'(por_width), 0);
        chk("t6b_por_cnt", int'(por_cnt), 0);
        repeat (2) @(negedge osc_ck);
        pwup_rsb = 1'b1;
        repeat (50) @(negedge osc_ck);
        chk("t6b_post_rstb", int'(rstb_out), 0);
        chk("t6b_post_busy", int'(busy), 0);
        chk("pending_events", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
